// File: rtl/outcome_demux_n.sv
// N-channel branch-outcome router: one registered stage that steers a resolved
// branch update to a single predictor bank and keeps per-channel miss statistics.
module outcome_demux_n #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 8,
    parameter bit HOLD_OT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      otcome,
    input  logic                      miss,
    input  logic                      clr_cnt,
    output logic [NUM_CH-1:0]         out_valid,
    output logic [NUM_CH-1:0]         ot,
    output logic [NUM_CH-1:0]         miss_out,
    output logic [NUM_CH*CNT_W-1:0]   miss_cnt,
    output logic                      bad_addr,
    output logic [CNT_W-1:0]          bad_cnt
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [NUM_CH-1:0]            sel;
    logic                         bad;

    logic [NUM_CH-1:0]            out_valid_d, out_valid_q;
    logic [NUM_CH-1:0]            ot_d,        ot_q;
    logic [NUM_CH-1:0]            miss_out_d,  miss_out_q;
    logic [NUM_CH-1:0][CNT_W-1:0] miss_cnt_d,  miss_cnt_q;
    logic                         bad_addr_d,  bad_addr_q;
    logic [CNT_W-1:0]             bad_cnt_d,   bad_cnt_q;

    // Address k+1 selects channel k; address 0 is a legal "no route".
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel[k] = in_valid && (addr == ADDR_W'(k + 1));
        end
        bad = in_valid && (addr > MAX_ADDR);
    end

    always_comb begin
        out_valid_d = sel;
        miss_out_d  = sel & {NUM_CH{miss}};
        bad_addr_d  = bad;
        ot_d        = '0;
        miss_cnt_d  = miss_cnt_q;
        bad_cnt_d   = bad_cnt_q;

        for (int k = 0; k < NUM_CH; k++) begin
            ot_d[k] = sel[k] ? otcome : (HOLD_OT ? ot_q[k] : 1'b0);
            if (sel[k] && miss && (miss_cnt_q[k] != CNT_MAX)) begin
                miss_cnt_d[k] = miss_cnt_q[k] + CNT_W'(1);
            end
        end

        if (bad && (bad_cnt_q != CNT_MAX)) begin
            bad_cnt_d = bad_cnt_q + CNT_W'(1);
        end

        // A clear in the same cycle as an increment wins; the increment is lost.
        if (clr_cnt) begin
            miss_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
        if (!rst_n) begin
            out_valid_q <= '0;
            ot_q        <= '0;
            miss_out_q  <= '0;
            miss_cnt_q  <= '0;
            bad_addr_q  <= 1'b0;
            bad_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ot_q        <= ot_d;
            miss_out_q  <= miss_out_d;
            miss_cnt_q  <= miss_cnt_d;
            bad_addr_q  <= bad_addr_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ot        = ot_q;
    assign miss_out  = miss_out_q;
    assign miss_cnt  = miss_cnt_q;
    assign bad_addr  = bad_addr_q;
    assign bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_outcome_demux_n.sv
// Bench for outcome_demux_n: two instances (ot cleared / ot held) share inputs and
// are compared every cycle against a channel-level model, plus directed literal checks.
module tb_outcome_demux_n;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;
    localparam int SAT    = 15;

    logic clk = 1'b0;
    logic rst_n, in_valid, otcome, miss, clr_cnt;
    logic [ADDR_W-1:0] addr;

    logic [NUM_CH-1:0]       ov0, ot0, mo0, ov1, ot1, mo1;
    logic [NUM_CH*CNT_W-1:0] mc0, mc1;
    logic                    ba0, ba1;
    logic [CNT_W-1:0]        bc0, bc1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: one entry per channel.
    int m_sel;
    bit m_ot_clr [NUM_CH];
    bit m_ot_hold[NUM_CH];
    int m_cnt    [NUM_CH];
    bit m_miss;
    bit m_bad;
    int m_bad_cnt;

    always #5 clk = ~clk;

    outcome_demux_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HOLD_OT(1'b0)) dut_clr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr(addr), .otcome(otcome),
        .miss(miss), .clr_cnt(clr_cnt), .out_valid(ov0), .ot(ot0), .miss_out(mo0),
        .miss_cnt(mc0), .bad_addr(ba0), .bad_cnt(bc0)
    );

    outcome_demux_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HOLD_OT(1'b1)) dut_hold (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr(addr), .otcome(otcome),
        .miss(miss), .clr_cnt(clr_cnt), .out_valid(ov1), .ot(ot1), .miss_out(mo1),
        .miss_cnt(mc1), .bad_addr(ba1), .bad_cnt(bc1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int a;
        a = int'(addr);
        if (!rst_n) begin
            m_sel = -1; m_miss = 0; m_bad = 0; m_bad_cnt = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_ot_clr[k] = 0; m_ot_hold[k] = 0; m_cnt[k] = 0;
            end
            return;
        end
        m_sel  = (in_valid && a >= 1 && a <= NUM_CH) ? a - 1 : -1;
        m_miss = (m_sel >= 0) && miss;
        m_bad  = in_valid && (a > NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            m_ot_clr[k] = (k == m_sel) ? otcome : 1'b0;
            if (k == m_sel) m_ot_hold[k] = otcome;
        end
        if (clr_cnt) begin
            for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;
            m_bad_cnt = 0;
        end else begin
            if (m_miss && m_cnt[m_sel] < SAT) m_cnt[m_sel]++;
            if (m_bad && m_bad_cnt < SAT) m_bad_cnt++;
        end
    endtask

    task automatic compare();
        logic [NUM_CH-1:0]       e_v, e_m, e_o0, e_o1;
        logic [NUM_CH*CNT_W-1:0] e_c;
        e_v = '0; e_m = '0; e_o0 = '0; e_o1 = '0; e_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            e_v[k]  = (k == m_sel);
            e_m[k]  = (k == m_sel) && m_miss;
            e_o0[k] = m_ot_clr[k];
            e_o1[k] = m_ot_hold[k];
            e_c[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        end
        check("out_valid",      {ov1, ov0}, {e_v, e_v});
        check("miss_out",       {mo1, mo0}, {e_m, e_m});
        check("ot_clr_mode",    ot0, e_o0);
        check("ot_hold_mode",   ot1, e_o1);
        check("miss_cnt",       {mc1, mc0}, {e_c, e_c});
        check("bad_addr",       {ba1, ba0}, {m_bad, m_bad});
        check("bad_cnt",        {bc1, bc0}, {CNT_W'(m_bad_cnt), CNT_W'(m_bad_cnt)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic drive(input bit v, input int a, input bit o, input bit m);
        in_valid = v; addr = ADDR_W'(a); otcome = o; miss = m;
    endtask

    logic [NUM_CH-1:0] route_exp [NUM_CH] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst_n = 1'b0; clr_cnt = 1'b0;
        drive(1, 2, 1, 1);
        tick();
        check("reset_out_valid", ov0, 4'b0000);
        check("reset_miss_cnt",  mc0, 16'h0000);
        rst_n = 1'b1;

        // Routing: addr 1..4 each deliver to one channel and count one miss.
        for (int a = 1; a <= NUM_CH; a++) begin
            drive(1, a, 1, 1);
            tick();
            check("route_out_valid", ov0, route_exp[a-1]);
        end
        check("route_miss_cnt", mc0, 16'h1111);
        check("route_bad_addr", ba0, 1'b0);

        // No-route and out-of-range addresses.
        drive(1, 0, 1, 1); tick();
        check("noroute_out_valid", ov0, 4'b0000);
        check("noroute_bad_addr",  ba0, 1'b0);
        drive(1, 5, 1, 1); tick();
        check("bad5_pulse", ba0, 1'b1);
        drive(1, 7, 1, 1); tick();
        check("bad7_pulse", ba0, 1'b1);
        drive(0, 0, 0, 0); tick();
        check("bad_pulse_end", ba0, 1'b0);
        check("bad_cnt_two",   bc0, 4'd2);
        check("bad_cnt_keep_miss_cnt", mc0, 16'h1111);

        // Saturation on channel 2.
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        drive(1, 3, 0, 1);
        repeat (20) tick();
        check("sat_miss_cnt", mc0, 16'h0F00);

        // Clear colliding with an increment on channel 0.
        clr_cnt = 1'b1; drive(0, 0, 0, 0); tick(); clr_cnt = 1'b0;
        drive(1, 1, 0, 1);
        repeat (5) tick();
        check("pre_clear_cnt", mc0, 16'h0005);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        check("collide_cnt",      mc0, 16'h0000);
        check("collide_miss_out", mo0, 4'b0001);
        tick();
        check("post_collide_cnt", mc0, 16'h0001);

        // ot hold vs clear on channel 1.
        drive(1, 2, 1, 0); tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ot1", ot1[1], 1'b1);
            check("clr_ot1",  ot0[1], 1'b0);
        end

        // Reset mid-stream.
        for (int a = 1; a <= NUM_CH; a++) begin drive(1, a, 1, 1); tick(); end
        rst_n = 1'b0; drive(1, 2, 1, 1); tick();
        check("midreset_all",
              {ov0, ot0, mo0, mc0, ba0, bc0, ot1},
              {4'b0, 4'b0, 4'b0, 16'h0, 1'b0, 4'b0, 4'b0});
        rst_n = 1'b1; tick();
        check("after_reset_out_valid", ov0, 4'b0010);
        check("after_reset_miss_cnt",  mc0, 16'h0010);

        // Randomised stream with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            clr_cnt = ($urandom_range(0, 99) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
